difetto_obsr: RTL and testbench
===============================

Name: difetto_obsr

Overview:
- Output boundary-scan register: the counterpart of the input boundary-scan cell. It sits between a core output bus and its pad.
- In functional mode the pad follows the core. In test mode the pad is driven from an update register loaded through a serial capture/shift/update chain.
- Carries the no_boundary_scan and keep_hierarchy attributes so the insertion pass never wraps it.

Parameters:
- WIDTH, 1, number of boundary cells (bits); legal range 1 and up.
- CLK_POLARITY, 1'b1, 1 = all state updates on posedge CLK; 0 = negedge.
- TEST_POLARITY, 1'b1, level of TEST that selects test mode.
- SAFE_VALUE, {WIDTH{1'b0}}, pad value driven in test mode before the first UPDATE (used only with the optional feature).

Ports:
- CLK  input  1  clock; active edge per CLK_POLARITY.
- RST_N  input  1  synchronous active-low reset.
- TEST  input  1  test-mode select; compared against TEST_POLARITY.
- D  input  WIDTH  core-side output value.
- Q  output  WIDTH  pad-side value.
- CAPTURE  input  1  load the shift register from D.
- SHIFT  input  1  shift the chain one position.
- UPDATE  input  1  transfer the shift register to the update register.
- SI  input  1  scan in.
- SO  output  1  scan out.
- DONE  output  1  one-cycle pulse: a full WIDTH-bit shift has completed.

Behaviour:
- State: shift_reg[WIDTH], upd_reg[WIDTH], bit_cnt[$clog2(WIDTH+1)], done_r.
- Reset (RST_N=0 at an active edge): shift_reg=0, upd_reg=0, bit_cnt=0, done_r=0. After reset, SO=0 and DONE=0.
- Q is combinational:
  - TEST==TEST_POLARITY: Q = upd_reg.
  - Otherwise: Q = D.
  - Zero latency from D to Q in functional mode.
- SO = shift_reg[0], combinational from the register. Chain is LSB-out, MSB-in.
- Priority per active edge, with RST_N high:
  - CAPTURE: shift_reg <= D; bit_cnt <= 0.
  - else SHIFT: shift_reg <= {SI, shift_reg[WIDTH-1:1]}.
    - bit_cnt == WIDTH-1: bit_cnt <= 0 and done_r <= 1.
    - otherwise: bit_cnt <= bit_cnt+1.
  - else: hold shift_reg and bit_cnt.
- UPDATE is independent of CAPTURE/SHIFT: upd_reg <= shift_reg value before the edge. UPDATE together with SHIFT loads the pre-shift contents.
- done_r is cleared on every edge where it is not set, so DONE is exactly one cycle wide.
- Back-to-back full shifts produce one DONE per WIDTH shifts.
- WIDTH=1: every SHIFT produces DONE.
- SHIFT gaps (SHIFT low mid-sequence) pause bit_cnt; the count is not lost.
- Reset mid-shift discards partial contents and count. upd_reg returns to 0, so in test mode Q=0 on the next cycle.
- CAPTURE, SHIFT and UPDATE work regardless of TEST; only Q selection depends on TEST.

Optional Feature:
- Macro: DIFETTO_OBSR_SAFE_EN.
- Defined:
  - Adds an internal flag `armed`, reset to 0 and set on the first UPDATE edge.
  - In test mode, Q = SAFE_VALUE while armed=0, and Q = upd_reg once armed=1.
  - armed stays set until the next reset.
- Undefined: no flag; in test mode Q = upd_reg from reset (zeros). SAFE_VALUE is ignored.

Test Plan (WIDTH=4, polarities 1):
- Reset, then TEST=0 with D=4'hA -> Q=4'hA in the same cycle; TEST=1 -> Q=4'h0; SO=0 and DONE=0.
- CAPTURE with D=4'h9, then 4 SHIFTs with SI=1,0,1,1 -> SO sequence 1,0,0,1. DONE is high only in the cycle after the 4th shift. shift_reg=4'hD.
- After that sequence, UPDATE with TEST=1 -> Q=4'hD from the next cycle. TEST=0 -> Q=D.
- SHIFT and UPDATE in the same cycle from shift_reg=4'h5 with SI=0 -> upd_reg=4'h5, shift_reg=4'h2. CAPTURE+SHIFT in the same cycle -> capture wins, bit_cnt=0, no DONE.
- 2 SHIFTs, 3 idle cycles, 2 SHIFTs -> DONE fires once, after the 4th shift. Repeat with RST_N low after the 2nd shift -> no DONE, Q=0 in test mode.
- With DIFETTO_OBSR_SAFE_EN and SAFE_VALUE=4'h6: after reset with TEST=1 -> Q=4'h6. After the first UPDATE of 4'h3 -> Q=4'h3. After reset -> Q=4'h6 again.

Source files
------------

// File: rtl/difetto_obsr.sv
// ---------------------------------------------------------------------------
// difetto_obsr -- output boundary-scan register
//
// Sits between a core output bus and its pads. In functional mode the pad
// follows the core with zero latency. In test mode the pad is driven from an
// update register that is loaded through a serial capture/shift/update chain
// (LSB out on SO, MSB in from SI).
//
// Parameters:
//   WIDTH          number of boundary cells (>= 1)
//   CLK_POLARITY   1: state changes on posedge CLK, 0: on negedge CLK
//   TEST_POLARITY  level of TEST that selects test mode
//   SAFE_VALUE     pad value in test mode before the first UPDATE
//                  (only with DIFETTO_OBSR_SAFE_EN defined)
//
// Ports:
//   CLK      clock, active edge per CLK_POLARITY
//   RST_N    synchronous active-low reset
//   TEST     test-mode select
//   D        core-side value          Q     pad-side value
//   CAPTURE  load chain from D        SHIFT shift chain one position
//   UPDATE   chain -> update register SI/SO scan in / scan out
//   DONE     one-cycle pulse after every full WIDTH-bit shift
//
// Optional feature macro: DIFETTO_OBSR_SAFE_EN
//   Defined: Q = SAFE_VALUE in test mode until the first UPDATE after reset.
//   Undefined: Q = update register in test mode from reset (zeros).
// ---------------------------------------------------------------------------
(* keep_hierarchy = "yes", no_boundary_scan = 1 *)
module difetto_obsr #(
    parameter int unsigned      WIDTH         = 1,
    parameter logic             CLK_POLARITY  = 1'b1,
    parameter logic             TEST_POLARITY = 1'b1,
    parameter logic [WIDTH-1:0] SAFE_VALUE    = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             TEST,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    input  logic             CAPTURE,
    input  logic             SHIFT,
    input  logic             UPDATE,
    input  logic             SI,
    output logic             SO,
    output logic             DONE
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef struct packed {
        logic [WIDTH-1:0] shift_reg;
        logic [WIDTH-1:0] upd_reg;
        logic [CNT_W-1:0] bit_cnt;
        logic             done_r;
`ifdef DIFETTO_OBSR_SAFE_EN
        logic             armed;
`endif
    } state_t;

    state_t           st_q;
    state_t           st_d;
    logic [WIDTH-1:0] shifted;
    logic             test_mode;

    // Chain moves toward the LSB; a 1-bit chain simply takes SI.
    if (WIDTH == 1) begin : g_shift_one
        assign shifted = SI;
    end else begin : g_shift_many
        assign shifted = {SI, st_q.shift_reg[WIDTH-1:1]};
    end

    // Next-state logic is shared by both clock-polarity variants below.
    always_comb begin
        // NOTE: every field gets a default before any branch, so no path
        // leaves a variable unassigned and no latch is inferred.
        st_d        = st_q;
        st_d.done_r = 1'b0;     // DONE is a single-cycle pulse
        if (!RST_N) begin
            st_d = '0;
        end else begin
            if (CAPTURE) begin
                st_d.shift_reg = D;
                st_d.bit_cnt   = '0;
            end else if (SHIFT) begin
                st_d.shift_reg = shifted;
                if (st_q.bit_cnt == CNT_LAST) begin
                    st_d.bit_cnt = '0;
                    st_d.done_r  = 1'b1;
                end else begin
                    st_d.bit_cnt = st_q.bit_cnt + 1'b1;
                end
            end
            // UPDATE samples the pre-edge chain, so it combines freely with
            // SHIFT or CAPTURE in the same cycle.
            if (UPDATE) begin
                st_d.upd_reg = st_q.shift_reg;
`ifdef DIFETTO_OBSR_SAFE_EN
                st_d.armed   = 1'b1;
`endif
            end
        end
    end

    if (CLK_POLARITY) begin : g_posedge
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its input from before the edge.
        always_ff @(posedge CLK) st_q <= st_d;
    end else begin : g_negedge
        always_ff @(negedge CLK) st_q <= st_d;
    end

    assign test_mode = (TEST == TEST_POLARITY);
    assign SO        = st_q.shift_reg[0];
    assign DONE      = st_q.done_r;

`ifdef DIFETTO_OBSR_SAFE_EN
    assign Q = !test_mode  ? D
             : st_q.armed  ? st_q.upd_reg
             :               SAFE_VALUE;
`else
    assign Q = test_mode ? st_q.upd_reg : D;

    // SAFE_VALUE has no role in this build.
    logic unused_safe_value;
    assign unused_safe_value = ^SAFE_VALUE;
`endif

endmodule

// File: tb/tb_difetto_obsr.sv
// ---------------------------------------------------------------------------
// tb_difetto_obsr -- directed bench for difetto_obsr (WIDTH=4, polarities 1)
//
// Drives inputs 1 time unit after the rising edge and samples outputs at the
// same point, i.e. well away from the active edge. Build with
// DIFETTO_OBSR_SAFE_EN defined to cover the safe-value feature
// (SAFE_VALUE = 4'h6).
// ---------------------------------------------------------------------------
module tb_difetto_obsr;

    localparam int unsigned W       = 4;
    localparam logic [3:0]  SAFE    = 4'h6;
`ifdef DIFETTO_OBSR_SAFE_EN
    localparam logic [3:0]  Q_IDLE  = 4'h6;   // test-mode pad before UPDATE
`else
    localparam logic [3:0]  Q_IDLE  = 4'h0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         test;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         capture;
    logic         shift;
    logic         update;
    logic         si;
    logic         so;
    logic         done;

    int checks   = 0;
    int failures = 0;

    difetto_obsr #(
        .WIDTH         (W),
        .CLK_POLARITY  (1'b1),
        .TEST_POLARITY (1'b1),
        .SAFE_VALUE    (SAFE)
    ) dut (
        .CLK     (clk),
        .RST_N   (rst_n),
        .TEST    (test),
        .D       (d),
        .Q       (q),
        .CAPTURE (capture),
        .SHIFT   (shift),
        .UPDATE  (update),
        .SI      (si),
        .SO      (so),
        .DONE    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_bit(input logic si_v);
        shift = 1'b1;
        si    = si_v;
        tick();
        shift = 1'b0;
        si    = 1'b0;
    endtask

    task automatic do_capture(input logic [W-1:0] val);
        capture = 1'b1;
        d       = val;
        tick();
        capture = 1'b0;
    endtask

    task automatic do_update();
        update = 1'b1;
        tick();
        update = 1'b0;
    endtask

    logic [3:0] si_vec;
    logic [3:0] so_vec;

    initial begin
        rst_n = 1'b0; test = 1'b0; d = '0; capture = 1'b0;
        shift = 1'b0; update = 1'b0; si = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state and functional pass-through
        check("reset_so", 32'(so), 0);
        check("reset_done", 32'(done), 0);
        test = 1'b0; d = 4'hA; #1;
        check("func_q_a", 32'(q), 32'hA);
        test = 1'b1; #1;
        check("test_q_reset", 32'(q), 32'(Q_IDLE));

        // Capture 9 then shift SI=1,0,1,1; SO before each shift is 1,0,0,1
        do_capture(4'h9);
        check("capture_q_untouched", 32'(q), 32'(Q_IDLE));
        si_vec = 4'b1101;   // bit i is SI of shift i
        so_vec = 4'b1001;   // bit i is SO expected before shift i
        for (int i = 0; i < 4; i++) begin
            check($sformatf("so_seq_%0d", i), 32'(so), 32'(so_vec[i]));
            shift_bit(si_vec[i]);
            check($sformatf("done_seq_%0d", i), 32'(done), (i == 3) ? 1 : 0);
        end
        tick();
        check("done_one_cycle", 32'(done), 0);
        check("so_after_d", 32'(so), 1);

        // UPDATE loads 4'hD onto the pad in test mode
        do_update();
        check("upd_q_d", 32'(q), 32'hD);
        test = 1'b0; d = 4'h3; #1;
        check("func_q_3", 32'(q), 32'h3);
        test = 1'b1; #1;
        check("test_q_d_again", 32'(q), 32'hD);

        // SHIFT + UPDATE together: update gets pre-shift 5, chain becomes 2
        do_capture(4'h5);
        shift = 1'b1; update = 1'b1; si = 1'b0;
        tick();
        shift = 1'b0; update = 1'b0;
        check("shupd_q_5", 32'(q), 32'h5);
        check("shupd_so_2", 32'(so), 0);
        shift_bit(1'b0);
        check("shupd_so_1", 32'(so), 1);

        // CAPTURE + SHIFT together: capture wins and count restarts at 0
        capture = 1'b1; shift = 1'b1; si = 1'b1; d = 4'hE;
        tick();
        capture = 1'b0; shift = 1'b0; si = 1'b0;
        check("capshift_so", 32'(so), 0);
        check("capshift_done", 32'(done), 0);
        for (int i = 0; i < 4; i++) begin
            shift_bit(1'b0);
            check($sformatf("capshift_done_%0d", i), 32'(done), (i == 3) ? 1 : 0);
        end

        // Gaps in SHIFT pause the count
        do_capture(4'h0);
        shift_bit(1'b1);
        shift_bit(1'b1);
        check("gap_done_2", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("gap_idle_%0d", i), 32'(done), 0);
        end
        shift_bit(1'b1);
        check("gap_done_3", 32'(done), 0);
        shift_bit(1'b1);
        check("gap_done_4", 32'(done), 1);
        tick();
        check("gap_done_clear", 32'(done), 0);
        do_update();
        check("gap_q_f", 32'(q), 32'hF);

        // Back-to-back full shift: exactly one DONE per 4 shifts
        for (int i = 0; i < 4; i++) begin
            shift_bit(1'b0);
            check($sformatf("b2b_done_%0d", i), 32'(done), (i == 3) ? 1 : 0);
        end
        check("b2b_so", 32'(so), 0);

        // Reset mid-shift discards contents, count and update register
        do_capture(4'hF);
        shift_bit(1'b1);
        shift_bit(1'b1);
        check("mid_so_before_rst", 32'(so), 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_q", 32'(q), 32'(Q_IDLE));
        check("mid_rst_so", 32'(so), 0);
        check("mid_rst_done", 32'(done), 0);
        for (int i = 0; i < 4; i++) begin
            shift_bit(1'b0);
            check($sformatf("mid_rst_done_%0d", i), 32'(done), (i == 3) ? 1 : 0);
        end
        check("mid_rst_q_hold", 32'(q), 32'(Q_IDLE));

        // First UPDATE after reset puts 4'h3 on the pad
        do_capture(4'h3);
        do_update();
        check("post_rst_upd_q", 32'(q), 32'h3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("final_rst_q", 32'(q), 32'(Q_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
